// File: rtl/ifetch_queue.sv
// Instruction-fetch stage: issues in-order imem requests from the current PC,
// pairs each response with its PC and buffers {inst, pc} for decode.
// Redirects flush the buffer and discard responses still owed for old requests.
// Optional feature macro: IFETCH_ALIGN_CHECK_EN (sticky align_err, word-aligned
// redirect target).
module ifetch_queue #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_cur,
  output logic [31:0] pc_next,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
`ifdef IFETCH_ALIGN_CHECK_EN
  ,
  output logic        align_err
`endif
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  // Instruction queue
  logic [31:0] q_inst_q [DEPTH];
  logic [31:0] q_inst_d [DEPTH];
  logic [31:0] q_pc_q   [DEPTH];
  logic [31:0] q_pc_d   [DEPTH];
  ptr_t        q_head_q, q_head_d;
  ptr_t        q_tail_q, q_tail_d;
  cnt_t        count_q,  count_d;

  // PCs of requests accepted by memory but not yet answered
  logic [31:0] ifl_pc_q [DEPTH];
  logic [31:0] ifl_pc_d [DEPTH];
  ptr_t        ifl_rd_q, ifl_rd_d;
  ptr_t        ifl_wr_q, ifl_wr_d;
  cnt_t        inflight_q, inflight_d;

  // Responses still owed for requests issued before the last redirect
  cnt_t        drop_q, drop_d;

  logic [CntW:0] occupancy;
  logic          has_credit;
  logic          req_fire;
  logic          rsp_take;
  logic          rsp_keep;
  logic          q_pop;
  logic [31:0]   redirect_tgt;

`ifdef IFETCH_ALIGN_CHECK_EN
  logic align_err_q, align_err_d;
  assign align_err    = align_err_q;
  assign redirect_tgt = {redirect_pc[31:2], 2'b00};
`else
  assign redirect_tgt = redirect_pc;
`endif

  // Handshake decode, next-PC selection and head-of-queue outputs
  always_comb begin
    // Credit counts in-flight requests so the queue can never overflow
    occupancy      = {1'b0, count_q} + {1'b0, inflight_q};
    has_credit     = occupancy < (CntW + 1)'(DEPTH);
    imem_req_valid = !rst && !redirect && has_credit;
    imem_req_addr  = pc_cur;
    req_fire       = imem_req_valid && imem_req_ready;
    // A response with nothing in flight is a protocol violation; ignore it
    rsp_take       = imem_rsp_valid && (inflight_q != '0);
    rsp_keep       = rsp_take && !redirect && (drop_q == '0);
    inst_valid     = (count_q != '0);
    inst           = q_inst_q[q_head_q];
    inst_pc        = q_pc_q[q_head_q];
    q_pop          = inst_valid && inst_ready && !redirect;

    if (rst) begin
      pc_next = 32'h0;
    end else if (redirect) begin
      pc_next = redirect_tgt;
    end else if (req_fire) begin
      pc_next = pc_cur + 32'd4;
    end else begin
      pc_next = pc_cur;
    end
  end

  // Next-state for the queue, in-flight FIFO and stale-response counter
  always_comb begin
    q_inst_d   = q_inst_q;
    q_pc_d     = q_pc_q;
    q_head_d   = q_head_q;
    q_tail_d   = q_tail_q;
    count_d    = count_q;
    ifl_pc_d   = ifl_pc_q;
    ifl_rd_d   = ifl_rd_q;
    ifl_wr_d   = ifl_wr_q;
    inflight_d = inflight_q + cnt_t'(req_fire) - cnt_t'(rsp_take);
    drop_d     = drop_q;

    if (req_fire) begin
      ifl_pc_d[ifl_wr_q] = pc_cur;
      ifl_wr_d           = ifl_wr_q + 1'b1;
    end
    if (rsp_take) begin
      ifl_rd_d = ifl_rd_q + 1'b1;
    end

    if (redirect) begin
      // Everything still in flight is stale, except a response consumed right now
      drop_d   = inflight_q - cnt_t'(rsp_take);
      q_head_d = '0;
      q_tail_d = '0;
      count_d  = '0;
    end else begin
      if (rsp_take && (drop_q != '0)) begin
        drop_d = drop_q - 1'b1;
      end
      if (rsp_keep) begin
        q_inst_d[q_tail_q] = imem_rsp_data;
        q_pc_d[q_tail_q]   = ifl_pc_q[ifl_rd_q];
        q_tail_d           = q_tail_q + 1'b1;
      end
      if (q_pop) begin
        q_head_d = q_head_q + 1'b1;
      end
      count_d = count_q + cnt_t'(rsp_keep) - cnt_t'(q_pop);
    end
  end

`ifdef IFETCH_ALIGN_CHECK_EN
  // Sticky flag for a misaligned redirect target
  always_comb begin
    align_err_d = align_err_q | (redirect && (redirect_pc[1:0] != 2'b00));
  end
`endif

  // State registers; payload storage needs no reset
  always_ff @(posedge clk) begin
    q_inst_q <= q_inst_d;
    q_pc_q   <= q_pc_d;
    ifl_pc_q <= ifl_pc_d;
    if (rst) begin
      q_head_q   <= '0;
      q_tail_q   <= '0;
      count_q    <= '0;
      ifl_rd_q   <= '0;
      ifl_wr_q   <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
`ifdef IFETCH_ALIGN_CHECK_EN
      align_err_q <= 1'b0;
`endif
    end else begin
      q_head_q   <= q_head_d;
      q_tail_q   <= q_tail_d;
      count_q    <= count_d;
      ifl_rd_q   <= ifl_rd_d;
      ifl_wr_q   <= ifl_wr_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
`ifdef IFETCH_ALIGN_CHECK_EN
      align_err_q <= align_err_d;
`endif
    end
  end

endmodule
